button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
Per-channel synchronizer and debouncer for raw board push-buttons and switches in the waveform generator front panel.
- Each raw asynchronous input is brought into the i_clk domain through a flop chain.
- A level change is accepted only after it has held stable for DEBOUNCE_CYCLES clocks.
- The clean active-high level goes directly to the rising-edge detector stage, which turns presses into single-cycle mode/frequency step commands.

Parameters:
WIDTH, 1, number of independent button channels
DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a change (10 ms at 50 MHz); legal range >= 2
ACTIVE_LOW, 1, 1 = raw pressed level is 0 (board buttons); 0 = raw pressed level is 1
CNT_WIDTH (localparam), $clog2(DEBOUNCE_CYCLES), width of each per-channel counter

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_btn_raw  input  WIDTH  raw asynchronous button/switch pins
o_btn_level  output  WIDTH  debounced level, 1 = pressed, registered
o_busy  output  WIDTH  1 while the channel is qualifying a pending change, registered

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is synchronous and active-low, sampled only on the i_clk rising edge.
- Polarity: pressed = i_btn_raw ^ ACTIVE_LOW (XOR applied after sync, per bit).
- Reset, per channel:
  - Sync flops load the released raw level (ACTIVE_LOW ? 1 : 0).
  - Counter = 0, state = STABLE.
  - o_btn_level = 0, o_busy = 0.
- Sync: 2 flops per bit (3 with the optional feature). No logic between the sync flops.
- FSM, per channel:
  - STABLE: if synced pressed != o_btn_level, go to WAIT, cnt <= 0, o_busy <= 1. Otherwise hold.
  - WAIT, synced pressed == o_btn_level (bounce back): go to STABLE, cnt <= 0, o_busy <= 0. o_btn_level is unchanged.
  - WAIT, still differs and cnt == DEBOUNCE_CYCLES-1: o_btn_level <= ~o_btn_level, go to STABLE, cnt <= 0, o_busy <= 0.
  - WAIT, otherwise: cnt <= cnt + 1.
- Latency: a clean raw change first sampled at edge N updates o_btn_level at edge N + SYNC_STAGES + DEBOUNCE_CYCLES. The default sync is 2, giving N + 2 + D.
- A glitch shorter than DEBOUNCE_CYCLES synced clocks never reaches o_btn_level. The counter restarts from 0 on the next differing sample.
- Counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1, and no wrap-around is possible.
- Channels are fully independent; simultaneous presses on several bits are each qualified separately.
- Reset asserted mid-WAIT: the pending change is discarded and all outputs return to reset values on that edge. After release, a still-held button is re-qualified with the full latency.
- o_btn_level changes at most once per DEBOUNCE_CYCLES+1 clocks per channel, so the downstream edge detector sees at most one rising edge per accepted press.

Optional Feature:
Macro: BUTTON_DEBOUNCE_SYNC3_EN
- Defined: 3-flop synchronizer per bit, SYNC_STAGES = 3, latency N + 3 + D. Used for fast i_clk builds.
- Undefined: 2-flop synchronizer, SYNC_STAGES = 2, latency N + 2 + D.
- Neither setting changes the FSM.

Decomposition:
- Shared package waveform_pkg holds:
  - typedef enum logic {ST_STABLE, ST_WAIT} debounce_state_e
  - localparam SYNC_STAGES (derived from the macro)
  - localparam CLK_FREQ_HZ (50_000_000), used by the top level to compute DEBOUNCE_CYCLES
- One sub-module, debounce_channel: single-bit sync chain + counter + FSM. button_debounce instantiates it WIDTH times in a generate loop.

Test Plan:
- Clean press, D=4, WIDTH=1, ACTIVE_LOW=1:
  - Stimulus: i_btn_raw 1->0 sampled at edge 10.
  - Required: o_busy=1 from edge 12; o_btn_level=1 at edge 16; o_busy=0 at edge 16.
- Bounce, D=4:
  - Stimulus: raw toggles 0/1/0/1 every 2 clocks for 12 clocks, then holds 0.
  - Required: o_btn_level stays 0 during bouncing; rises exactly 6 clocks after the final stable sample.
- Release: from pressed, raw 0->1 held → o_btn_level falls to 0 after 6 clocks.
- Reset mid-WAIT:
  - Stimulus: press held; assert i_rst_n=0 at cnt=2 for 1 clock, then release reset with the button still held.
  - Required: outputs 0 on the reset edge; o_btn_level=1 a full 6 clocks after the first post-reset sampling edge.
- Multi-channel, WIDTH=4, D=4:
  - Stimulus: bits 0 and 3 pressed on the same edge, bit 1 given a 2-clock glitch.
  - Required: o_btn_level=4'b1001 at +6; bit 1 never asserted.
- BUTTON_DEBOUNCE_SYNC3_EN defined, D=4: repeat the clean press → o_btn_level=1 at edge 17.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg: shared types and constants for the front-panel button debouncer.
//   Provides debounce_state_e, SYNC_STAGES and CLK_FREQ_HZ.
//   Macro BUTTON_DEBOUNCE_SYNC3_EN selects a 3-flop synchronizer; the default is 2 flops.
package waveform_pkg;
   typedef enum logic {ST_STABLE, ST_WAIT} debounce_state_e;
`ifdef BUTTON_DEBOUNCE_SYNC3_EN
   localparam int SYNC_STAGES = 3;
`else
   localparam int SYNC_STAGES = 2;
`endif
   localparam int CLK_FREQ_HZ = 50_000_000;
endpackage

// File: rtl/button_debounce_channel.sv
// debounce_channel: single-bit synchronizer, stability counter and accept FSM.
//   i_clk       system clock
//   i_rst_n     synchronous active-low reset
//   i_btn_raw   raw asynchronous pin
//   o_btn_level debounced level, 1 = pressed
//   o_busy      1 while a pending change is being qualified
//   Synchronizer depth follows SYNC_STAGES (macro BUTTON_DEBOUNCE_SYNC3_EN).
module debounce_channel
   import waveform_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic ACTIVE_LOW      = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_raw,
   output logic o_btn_level,
   output logic o_busy
);
   localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync_q;
   debounce_state_e state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic level_q, level_d, busy_q, busy_d;
   logic pressed;
   assign pressed = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         // preload the released level so reset release never looks like a press
         sync_q  <= {SYNC_STAGES{ACTIVE_LOW}};
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], i_btn_raw};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         busy_q  <= busy_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      busy_d  = busy_q;
      if (state_q == ST_STABLE) begin
         if (pressed != level_q) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            busy_d  = 1'b1;
         end
      end else if (pressed == level_q) begin
         state_d = ST_STABLE;
         cnt_d   = '0;
         busy_d  = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = ~level_q;
         state_d = ST_STABLE;
         cnt_d   = '0;
         busy_d  = 1'b0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end
   assign o_btn_level = level_q;
   assign o_busy      = busy_q;
endmodule

// File: rtl/button_debounce.sv
// button_debounce: per-channel synchronizer and debouncer for front-panel buttons.
//   i_clk       system clock
//   i_rst_n     synchronous active-low reset
//   i_btn_raw   WIDTH raw asynchronous pins
//   o_btn_level WIDTH debounced levels, 1 = pressed
//   o_busy      WIDTH flags, 1 while a channel qualifies a pending change
//   Macro BUTTON_DEBOUNCE_SYNC3_EN selects a 3-flop synchronizer (default 2).
module button_debounce
   import waveform_pkg::*;
#(
   parameter int   WIDTH           = 1,
   parameter int   DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100,
   parameter logic ACTIVE_LOW      = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_btn_raw,
   output logic [WIDTH-1:0] o_btn_level,
   output logic [WIDTH-1:0] o_busy
);
   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_btn_raw  (i_btn_raw[g]),
         .o_btn_level(o_btn_level[g]),
         .o_busy     (o_busy[g])
      );
   end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: vector table, corner sequences and random stimulus against a run-length model.
module tb_button_debounce;
   localparam int S = waveform_pkg::SYNC_STAGES;
   localparam int D = 4;
   localparam int N = 60;
   typedef struct {
      logic [3:0] raw;
      logic       rn;
      logic [3:0] lvl;
      logic [3:0] busy;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] raw = 4'hF;
   logic [3:0] lvl, busy;
   logic       raw2, lvl2, busy2;
   int total = 0;
   int bad = 0;
   logic [3:0] lvl_m = 4'h0;
   logic [3:0] busy_m = 4'h0;
   int         run_m[4];
   logic [3:0] hist[$];
   vec_t       tbl[N];
   assign raw2 = ~raw[0];
   always #5 clk = ~clk;
   button_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_btn_raw(raw), .o_btn_level(lvl), .o_busy(busy));
   button_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_btn_raw(raw2), .o_btn_level(lvl2), .o_busy(busy2));
   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask
   // reference: the level flips once the synchronized pressed value has differed
   // from it on D+1 consecutive edges; busy whenever such a run is in progress
   task automatic model_edge(input logic [3:0] r, input logic rn);
      logic [3:0] p;
      if (!rn) begin
         hist.delete();
         lvl_m = 4'h0;
         busy_m = 4'h0;
         for (int i = 0; i < 4; i++) run_m[i] = 0;
         return;
      end
      p = (hist.size() >= S) ? hist[S-1] : 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (p[i] != lvl_m[i]) begin
            run_m[i]++;
            if (run_m[i] == D + 1) begin
               lvl_m[i] = ~lvl_m[i];
               run_m[i] = 0;
            end
         end else run_m[i] = 0;
         busy_m[i] = (run_m[i] != 0);
      end
      hist.push_front(~r);
      if (hist.size() > S + 1) void'(hist.pop_back());
   endtask
   task automatic cyc(input logic [3:0] r, input logic rn);
      raw = r;
      rst_n = rn;
      @(posedge clk);
      model_edge(r, rn);
      @(negedge clk);
   endtask
   // expected {level,busy} after edge k for one press sampled from edge a for g edges
   function automatic logic [1:0] pulse(input int k, input int a, input int g);
      int s, e;
      logic l, b;
      s = a + S;
      e = a + g + S;
      if (g > D) begin
         l = (k >= s + D) && (k < e + D);
         b = ((k >= s) && (k < s + D)) || ((k >= e) && (k < e + D));
      end else begin
         l = 1'b0;
         b = (k >= s) && (k < e);
      end
      return {l, b};
   endfunction
   initial begin
      #10ms;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      logic [1:0] c0, c1, c3;
      for (int i = 0; i < 4; i++) run_m[i] = 0;
      for (int k = 0; k < N; k++) begin
         c0 = pulse(k, 10, 10) | pulse(k, 32, 12);
         c1 = pulse(k, 34, 2);
         c3 = pulse(k, 32, 12);
         tbl[k].rn   = (k != 0);
         tbl[k].raw  = 4'hF;
         if ((k >= 10 && k < 20) || (k >= 32 && k < 44)) tbl[k].raw[0] = 1'b0;
         if (k >= 34 && k < 36) tbl[k].raw[1] = 1'b0;
         if (k >= 32 && k < 44) tbl[k].raw[3] = 1'b0;
         tbl[k].lvl  = {c3[1], 1'b0, c1[1], c0[1]};
         tbl[k].busy = {c3[0], 1'b0, c1[0], c0[0]};
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         cyc(tbl[k].raw, tbl[k].rn);
         chk("tbl_level", lvl, tbl[k].lvl);
         chk("tbl_busy", busy, tbl[k].busy);
         chk("tbl_level_ahi", {3'b0, lvl2}, {3'b0, tbl[k].lvl[0]});
         chk("tbl_busy_ahi", {3'b0, busy2}, {3'b0, tbl[k].busy[0]});
      end
      for (int j = 0; j <= 12 + S + D; j++) begin
         cyc((j < 12 && ((j / 2) % 2) != 0) ? 4'hF : 4'hE, 1'b1);
         chk("bounce_level", {3'b0, lvl[0]}, {3'b0, j >= 12 + S + D});
      end
      for (int j = 0; j <= S + D; j++) begin
         cyc(4'hF, 1'b1);
         chk("release_level", {3'b0, lvl[0]}, {3'b0, j < S + D});
      end
      for (int j = 0; j < 3; j++) cyc(4'hF, 1'b1);
      for (int j = 0; j <= S + 2; j++) cyc(4'hE, 1'b1);
      chk("midwait_busy", busy, 4'h1);
      cyc(4'hE, 1'b0);
      chk("rst_level", lvl, 4'h0);
      chk("rst_busy", busy, 4'h0);
      for (int j = 0; j <= S + D; j++) begin
         cyc(4'hE, 1'b1);
         chk("requal_level", {3'b0, lvl[0]}, {3'b0, j >= S + D});
      end
      for (int j = 0; j < S + D + 3; j++) cyc(4'hF, 1'b1);
      for (int j = 0; j < 3000; j++) begin
         logic [3:0] r;
         r = raw;
         for (int i = 0; i < 4; i++) if ($urandom_range(5) == 0) r[i] = ~r[i];
         cyc(r, $urandom_range(299) != 0);
         chk("rnd_level", lvl, lvl_m);
         chk("rnd_busy", busy, busy_m);
         chk("rnd_level_ahi", {3'b0, lvl2}, {3'b0, lvl_m[0]});
         chk("rnd_busy_ahi", {3'b0, busy2}, {3'b0, busy_m[0]});
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
